counter_cmd_seq: RTL

- Command sequencer directly upstream of the 4-bit up/down counter.
- Accepts LOAD/UP/DOWN/NOP commands over a valid/ready handshake.
- Drives the counter's en/ld/dir/ld_val inputs cycle by cycle, then pulses done.
- Converts "step N times up/down" into N single-cycle enable pulses, so software and test logic never hand-toggle the counter controls.

---
 rtl/counter_pkg.sv | 32 +++
 rtl/counter_seq_pacer.sv | 36 +++
 rtl/counter_cmd_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_pkg
//  Brief    : Shared types and default sizes for the 4-bit counter and its
//             command sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Defaults shared with the downstream up/down counter
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // Command opcodes as carried on cmd_op
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } cnt_op_e;

  // Sequencer states; ST_GAP is only reachable in paced builds
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_STEP = 3'd2,
    ST_DONE = 3'd3,
    ST_GAP  = 3'd4
  } seq_state_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_seq_pacer.sv
`default_nettype none
// ============================================================================
//  Module   : counter_seq_pacer
//  Brief    : Gap timer for the command sequencer. i_start loads PACE; the
//             counter then runs down and o_expired pulses in the last gap
//             cycle so the sequencer can return to STEP on the next edge.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_seq_pacer #(
  parameter int PACE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_expired
);

  localparam int PW = (PACE > 1) ? $clog2(PACE + 1) : 1;

  logic [PW-1:0] r_cnt;

  // Load on start, then count down to zero and park there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= PW'(PACE);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - PW'(1);
    end
  end

  assign o_expired = (r_cnt == PW'(1));

endmodule : counter_seq_pacer
`default_nettype wire

// File: rtl/counter_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : counter_cmd_seq
//  Brief    : Command sequencer in front of the up/down counter. Accepts
//             NOP/LOAD/UP/DOWN over valid/ready, expands "step N" into N
//             single-cycle enables and pulses done when finished.
//             Optional macro CNT_SEQ_PACE_EN inserts PACE idle (GAP) cycles
//             between consecutive steps.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_cmd_seq
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PACE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  output logic             cnt_en,
  output logic             cnt_ld,
  output logic             cnt_dir,
  output logic [WIDTH-1:0] cnt_ld_val,
  output logic             busy,
  output logic             done
);

  // Configuration sanity checks at elaboration
  if (CNT_W < WIDTH) begin : g_cfg_width_err
    $error("counter_cmd_seq: CNT_W must be >= WIDTH");
  end
  if (PACE < 0) begin : g_cfg_pace_err
    $error("counter_cmd_seq: PACE must be non-negative");
  end

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_rem;
  logic             r_dir;
  logic [WIDTH-1:0] r_ld_val;
  logic             w_accept;
  logic             w_is_step_op;
  logic             w_arg_zero;
  cnt_op_e          w_op;

  assign w_op         = cnt_op_e'(cmd_op);
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_is_step_op = (w_op == OP_UP) || (w_op == OP_DOWN);
  assign w_arg_zero   = (cmd_arg == '0);

`ifdef CNT_SEQ_PACE_EN
  logic w_gap_start;
  logic w_gap_expired;

  counter_seq_pacer #(
    .PACE (PACE)
  ) u_pacer (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_gap_start),
    .o_expired (w_gap_expired)
  );
`endif

  // State register; async reset aborts any command in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
`ifdef CNT_SEQ_PACE_EN
    w_gap_start = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_op == OP_LOAD) begin
            w_state_nxt = ST_LOAD;
          end else if (w_is_step_op && !w_arg_zero) begin
            w_state_nxt = ST_STEP;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_LOAD: w_state_nxt = ST_DONE;
      ST_STEP: begin
        if (r_rem == CNT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end else begin
`ifdef CNT_SEQ_PACE_EN
          if (PACE > 0) begin
            w_state_nxt = ST_GAP;
            w_gap_start = 1'b1;
          end else begin
            w_state_nxt = ST_STEP;
          end
`else
          w_state_nxt = ST_STEP;
`endif
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
`ifdef CNT_SEQ_PACE_EN
      ST_GAP: begin
        if (w_gap_expired) begin
          w_state_nxt = ST_STEP;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command data: step count, direction and load value captured at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem    <= '0;
      r_dir    <= 1'b0;
      r_ld_val <= '0;
    end else begin
      if (r_state == ST_IDLE && w_accept) begin
        if (w_op == OP_LOAD) begin
          r_ld_val <= cmd_arg[WIDTH-1:0];
        end else if (w_is_step_op && !w_arg_zero) begin
          r_rem <= cmd_arg;
          r_dir <= (w_op == OP_UP);
        end
      end else if (r_state == ST_STEP) begin
        // rem is always >= 1 here, so this never wraps
        r_rem <= r_rem - CNT_W'(1);
      end
    end
  end

  // Outputs are decoded from state or registered; no path from cmd_* to cnt_*
  assign cmd_ready  = (r_state == ST_IDLE) && !rst;
  assign cnt_en     = (r_state == ST_LOAD) || (r_state == ST_STEP);
  assign cnt_ld     = (r_state == ST_LOAD);
  assign cnt_dir    = r_dir;
  assign cnt_ld_val = r_ld_val;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);

endmodule : counter_cmd_seq
`default_nettype wire
